output_mems: RTL and testbench

Output stage of the matrix-multiply accelerator, mirroring the input-side AXI-Stream loader. Stores the M×N result matrix C as the compute engine writes it, one element per cycle. After `compute_finished`, streams C out in row-major order as an AXI-Stream master with TLAST on the final element. Signals `output_sent` so the controller can release the input memories for the next job.

---
 rtl/mm_pkg.sv | 15 +
 rtl/output_mems_if.sv | 26 ++
 rtl/output_mems_memory.sv | 46 ++++
 rtl/output_mems.sv | 123 ++++++++++++
 tb/tb_output_mems.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared matrix-multiply accelerator types and defaults.
// Used by the input loader, compute engine and output stage.
package mm_pkg;

    localparam int OUTW_DEF = 24;
    localparam int M_DEF    = 7;
    localparam int N_DEF    = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SEND
    } out_state_t;

endpackage

// File: rtl/output_mems_if.sv
// AXI-Stream result channel of the output stage.
// Master drives data/valid/last, slave drives ready.
interface output_mems_if #(
    parameter int OUTW = 24
);

    logic signed [OUTW-1:0] AXIS_TDATA;
    logic                   AXIS_TVALID;
    logic                   AXIS_TLAST;
    logic                   AXIS_TREADY;

    modport master (
        output AXIS_TDATA,
        output AXIS_TVALID,
        output AXIS_TLAST,
        input  AXIS_TREADY
    );

    modport slave (
        input  AXIS_TDATA,
        input  AXIS_TVALID,
        input  AXIS_TLAST,
        output AXIS_TREADY
    );

endinterface

// File: rtl/output_mems_memory.sv
// Single-port result store with registered read data.
// Port address follows the writer in IDLE, the streamer otherwise.
module output_memory
    import mm_pkg::*;
#(
    parameter int OUTW  = OUTW_DEF,
    parameter int DEPTH = M_DEF * N_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  out_state_t             state,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic signed [OUTW-1:0] wr_data,
    input  logic [AW-1:0]          rd_addr,
    output logic signed [OUTW-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic signed [OUTW-1:0] mem [DEPTH];
    logic signed [OUTW-1:0] rd_data_q;
    logic [AW-1:0]          addr;
    logic                   in_range;
    logic                   we;

    // Shared port address, range guard and IDLE-only write enable.
    always_comb begin
        addr     = (state == ST_IDLE) ? wr_addr : rd_addr;
        in_range = ({1'b0, addr} < DEPTH_W);
        we       = wr_en && (state == ST_IDLE) && in_range;
    end

    // Array write and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        if (in_range) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/output_mems.sv
// Result-matrix store and AXI-Stream row-major streamer.
// Holds the IDLE/PRIME/SEND FSM, read pointer and AXIS flags.
module output_mems
    import mm_pkg::*;
#(
    parameter int  OUTW        = OUTW_DEF,
    parameter int  M           = M_DEF,
    parameter int  N           = N_DEF,
    localparam int C_ADDR_BITS = $clog2(M * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [C_ADDR_BITS-1:0] C_write_addr,
    input  logic signed [OUTW-1:0] C_data_in,
    input  logic                   C_wr_en,
    input  logic                   compute_finished,
    output_mems_if.master          axis,
    output logic                   output_sent,
    output logic                   busy
);

    localparam logic [C_ADDR_BITS-1:0] LAST = C_ADDR_BITS'(M * N - 1);

    out_state_t             state_q;
    out_state_t             state_d;
    logic [C_ADDR_BITS-1:0] rd_ptr_q;
    logic [C_ADDR_BITS-1:0] rd_ptr_d;
    logic                   tvalid_q;
    logic                   tvalid_d;
    logic                   tlast_q;
    logic                   tlast_d;
    logic                   sent_q;
    logic                   sent_d;
    logic                   busy_q;
    logic                   busy_d;
    logic [C_ADDR_BITS-1:0] rd_addr;
    logic signed [OUTW-1:0] rd_data;
    logic                   hs;
    logic                   is_last;

    assign hs      = tvalid_q & axis.AXIS_TREADY;
    assign is_last = (rd_ptr_q == LAST);

    output_memory #(
        .OUTW  (OUTW),
        .DEPTH (M * N),
        .AW    (C_ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .state   (state_q),
        .wr_en   (C_wr_en),
        .wr_addr (C_write_addr),
        .wr_data (C_data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next state, pointer, look-ahead read address and output flags.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        sent_d   = 1'b0;
        rd_addr  = rd_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (compute_finished) begin
                    state_d  = ST_PRIME;
                    rd_ptr_d = '0;
                end
            end
            ST_PRIME: begin
                state_d = ST_SEND;
                rd_addr = '0;
            end
            ST_SEND: begin
                if (hs) begin
                    if (is_last) begin
                        state_d  = ST_IDLE;
                        rd_ptr_d = '0;
                        sent_d   = 1'b1;
                        rd_addr  = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        rd_addr  = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_ptr_d = '0;
            end
        endcase
        tvalid_d = (state_d == ST_SEND);
        tlast_d  = (state_d == ST_SEND) && (rd_ptr_d == LAST);
        busy_d   = (state_d != ST_IDLE);
    end

    // FSM state and registered outputs; reset clears the stream at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            sent_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            sent_q   <= sent_d;
            busy_q   <= busy_d;
        end
    end

    assign axis.AXIS_TDATA  = rd_data;
    assign axis.AXIS_TVALID = tvalid_q;
    assign axis.AXIS_TLAST  = tlast_q;
    assign output_sent      = sent_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_output_mems.sv
// Bench for output_mems at M=2, N=3: directed table plus random jobs.
// Streams are collected at handshakes and set against an array model.
module tb_output_mems;

    localparam int OUTW = 24;
    localparam int M    = 2;
    localparam int N    = 3;
    localparam int NE   = M * N;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [2:0]             C_write_addr = '0;
    logic signed [OUTW-1:0] C_data_in = '0;
    logic                   C_wr_en = 1'b0;
    logic                   compute_finished = 1'b0;
    logic                   output_sent;
    logic                   busy;

    output_mems_if #(.OUTW(OUTW)) axis ();

    output_mems #(
        .OUTW (OUTW),
        .M    (M),
        .N    (N)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .C_write_addr     (C_write_addr),
        .C_data_in        (C_data_in),
        .C_wr_en          (C_wr_en),
        .compute_finished (compute_finished),
        .axis             (axis),
        .output_sent      (output_sent),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] wa;
        int         wd;
        int         pos;
        int         exp;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ref_mem [NE];
    int   exp_tab [NE];
    int   got_data [$];
    bit   got_last [$];
    vec_t vt [8];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input int d);
        @(negedge clk);
        C_wr_en      = 1'b1;
        C_write_addr = a;
        C_data_in    = OUTW'(d);
        if (int'(a) < NE) ref_mem[a] = d;
    endtask

    task automatic run_job(input int mode, input bit pre, input bit interfere,
                           input bit chain, input bit sw,
                           input logic [2:0] sa, input int sd);
        int cyc;
        int beats;
        int hold_d;
        bit hold_l;
        bit pend;
        bit done;
        bit did;
        bit rdy;
        got_data.delete();
        got_last.delete();
        if (!pre) begin
            @(negedge clk);
            compute_finished = 1'b1;
            C_wr_en          = sw;
            C_write_addr     = sa;
            C_data_in        = OUTW'(sd);
        end
        @(negedge clk);
        compute_finished = 1'b0;
        C_wr_en          = 1'b0;
        check("prime", int'({axis.AXIS_TVALID, busy, output_sent}), 2);
        cyc   = 0;
        beats = 0;
        pend  = 0;
        done  = 0;
        did   = 0;
        hold_d = 0;
        hold_l = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            C_wr_en          = 1'b0;
            compute_finished = 1'b0;
            check("valid", int'(axis.AXIS_TVALID), 1);
            check("sent_early", int'(output_sent), 0);
            if (pend) begin
                check("hold_data", int'(axis.AXIS_TDATA), hold_d);
                check("hold_last", int'(axis.AXIS_TLAST), int'(hold_l));
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 1);
            else rdy = 1'($urandom_range(0, 1));
            if (interfere && beats == 2 && !did) begin
                C_wr_en          = 1'b1;
                C_write_addr     = 3'd0;
                C_data_in        = OUTW'(999);
                compute_finished = 1'b1;
                did              = 1'b1;
            end
            axis.AXIS_TREADY = rdy;
            if (axis.AXIS_TVALID && rdy) begin
                got_data.push_back(int'(axis.AXIS_TDATA));
                got_last.push_back(axis.AXIS_TLAST);
                beats++;
                pend = 0;
                if (beats == NE) done = 1;
            end else begin
                pend   = axis.AXIS_TVALID;
                hold_d = int'(axis.AXIS_TDATA);
                hold_l = axis.AXIS_TLAST;
            end
        end
        if (!done) check("timeout_beats", beats, NE);
        @(negedge clk);
        axis.AXIS_TREADY = 1'b0;
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
        check("sent_pulse",
              int'({output_sent, axis.AXIS_TVALID, busy, axis.AXIS_TLAST}), 8);
        if (chain) begin
            compute_finished = 1'b1;
        end else begin
            @(negedge clk);
            check("idle_after", int'({output_sent, axis.AXIS_TVALID, busy}), 0);
            @(negedge clk);
            check("no_restart", int'({axis.AXIS_TVALID, busy}), 0);
        end
    endtask

    task automatic cmp_stream(input int e [NE], input string tag);
        check({tag, "_count"}, got_data.size(), NE);
        for (int i = 0; i < got_data.size() && i < NE; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], e[i]);
            check($sformatf("%s_last%0d", tag, i), int'(got_last[i]),
                  int'(i == NE - 1));
        end
    endtask

    initial begin
        int hs;
        int cyc;
        int nw;
        bit sw;
        logic [2:0] sa;
        int sd;
        axis.AXIS_TREADY = 1'b0;
        vt[0] = '{3'd0, 10, 0, 10};
        vt[1] = '{3'd1, -20, 1, -20};
        vt[2] = '{3'd2, 30, 2, 30};
        vt[3] = '{3'd3, -40, 3, -40};
        vt[4] = '{3'd4, 50, 4, 50};
        vt[5] = '{3'd5, -60, 5, -60};
        vt[6] = '{3'd6, 777, 0, 10};
        vt[7] = '{3'd7, -5, 5, -60};

        repeat (2) @(negedge clk);
        check("reset_out", int'({axis.AXIS_TVALID, axis.AXIS_TLAST,
                                 output_sent, busy}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset", int'({axis.AXIS_TVALID, axis.AXIS_TLAST,
                                  output_sent, busy}), 0);

        for (int i = 0; i < 8; i++) begin
            wr(vt[i].wa, vt[i].wd);
            exp_tab[vt[i].pos] = vt[i].exp;
        end

        run_job(0, 0, 0, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "ready");

        run_job(1, 0, 0, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "toggle");

        run_job(0, 0, 1, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "interfere");
        run_job(0, 0, 0, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "after_interfere");

        @(negedge clk);
        compute_finished = 1'b1;
        @(negedge clk);
        compute_finished = 1'b0;
        axis.AXIS_TREADY = 1'b1;
        hs  = 0;
        cyc = 0;
        while (hs < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (axis.AXIS_TVALID) hs++;
        end
        check("pre_reset_beats", hs, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset_async", int'({axis.AXIS_TVALID, axis.AXIS_TLAST, busy}), 0);
        @(negedge clk);
        reset = 1'b0;
        axis.AXIS_TREADY = 1'b0;
        @(negedge clk);
        check("reset_idle", int'({axis.AXIS_TVALID, busy, output_sent}), 0);
        run_job(0, 0, 0, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "restart");

        run_job(0, 0, 0, 1, 0, 3'd0, 0);
        cmp_stream(exp_tab, "b2b_first");
        run_job(0, 1, 0, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "b2b_second");

        wr(3'd6, 4242);
        run_job(2, 0, 0, 0, 0, 3'd0, 0);
        cmp_stream(exp_tab, "oob");

        for (int r = 0; r < 8; r++) begin
            nw = int'($urandom_range(1, 5));
            for (int k = 0; k < nw; k++) begin
                wr(3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2000000)) - 1000000);
            end
            sw = 1'($urandom_range(0, 1));
            sa = 3'($urandom_range(0, 7));
            sd = int'($urandom_range(0, 2000000)) - 1000000;
            if (sw && int'(sa) < NE) ref_mem[sa] = sd;
            run_job(2, 0, 0, 0, sw, sa, sd);
            cmp_stream(ref_mem, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
